// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//   Valid/ready stream demultiplexer. Each accepted input beat is steered to
//   one of N_OUT output streams chosen by in_sel. Every output owns a one-entry
//   registered slot, so outputs are registered and back-pressure is applied
//   per destination: a stalled sink only blocks beats addressed to it.
//   Beats whose select is out of range (possible only when N_OUT is not a
//   power of two) are accepted, dropped and counted in a saturating err_cnt.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   in_valid   in   1            input beat present
//   in_ready   out  1            input beat accepted when in_valid && in_ready
//   in_data    in   WIDTH        input payload
//   in_sel     in   SEL_W        destination index, qualified by in_valid
//   out_valid  out  N_OUT        bit i: slot i holds a beat
//   out_ready  in   N_OUT        bit i: sink i accepts
//   out_data   out  N_OUT*WIDTH  slot i payload at [i*WIDTH +: WIDTH]
//   err_cnt    out  8            saturating count of dropped out-of-range beats
// -----------------------------------------------------------------------------
module stream_demux #(
  parameter  int WIDTH = 8,
  parameter  int N_OUT = 4,
  localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [7:0]             err_cnt
);

  // One bit wider than in_sel so the range check also works for N_OUT = 2**SEL_W.
  localparam logic [SEL_W:0] n_out_c = (SEL_W+1)'(N_OUT);

  logic [N_OUT-1:0]       valid_r;
  logic [N_OUT*WIDTH-1:0] data_r;
  logic [7:0]             err_r;

  logic                   sel_ok_s;
  logic                   ready_s;
  logic                   in_fire_s;
  logic [N_OUT-1:0]       match_s;
  logic [N_OUT-1:0]       load_s;

  // Decode the select, derive in_ready and the per-slot load strobes.
  always_comb begin
    sel_ok_s = ({1'b0, in_sel} < n_out_c);
    for (int i = 0; i < N_OUT; i++) begin
      match_s[i] = (in_sel == SEL_W'(i));
    end
    // A full slot can still take a beat when its sink drains it on the same
    // edge, which is what gives back-to-back pass-through without a bubble.
    if (!rst_n) begin
      ready_s = 1'b0;
    end else if (!sel_ok_s) begin
      ready_s = 1'b1;
    end else begin
      ready_s = |(match_s & (~valid_r | out_ready));
    end
    in_fire_s = in_valid && ready_s;
    // match_s is all-zero for an out-of-range select, so a dropped beat
    // never loads any slot.
    load_s = match_s & {N_OUT{in_fire_s}};
  end

  // Per-output slot state: load on an addressed input beat, drain on out_fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {N_OUT{1'b0}};
      data_r  <= {(N_OUT*WIDTH){1'b0}};
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (load_s[i]) begin
          valid_r[i]                <= 1'b1;
          data_r[i*WIDTH +: WIDTH]  <= in_data;
        end else if (valid_r[i] && out_ready[i]) begin
          // Data slice is left as-is; sinks ignore it while the slot is empty.
          valid_r[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating drop counter for out-of-range selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 8'd0;
    end else if (in_fire_s && !sel_ok_s && (err_r != 8'hFF)) begin
      err_r <= err_r + 8'd1;
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign err_cnt   = err_r;

endmodule
